uart_bus_responder: RTL and testbench
=====================================

Name: uart_bus_responder

Overview:
- UART peripheral that is a responder on the single program/data bus driven by the RV32I lite core.
- Same addr/wr/rd/bus_in/bus_out handshake as the other bus peripherals.
- bus_out is zero when not selected, so it feeds the OR-type bus_dmux directly.
- Contains a TX FIFO with serializer, an RX deserializer with one-byte holding register, and a programmable baud divisor.

Parameters:
- BUS_ADDR_DATA_LEN, 13: width of the addr port.
- DATA_ADDR, 'h00: TX push on write, RX pop on read.
- STATUS_ADDR, 'h04: status read; write-1-to-clear of sticky bits.
- BAUD_ADDR, 'h08: baud divisor register, R/W, bits [15:0].
- TX_FIFO_DEPTH_LOG2, 2: TX FIFO depth is 2**N, so 4 entries.
- BAUD_DIV_RESET, 16'd433: divisor after reset. Bit period = BAUD+1 clocks.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  BUS_ADDR_DATA_LEN  byte address, already decoded to this peripheral's window.
- wr  in  1  word write strobe, qualified by chip select at top level.
- rd  in  1  chip select / read enable.
- bus_in  in  32  write data.
- bus_out  out  32  read data, registered.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous.

Behaviour:
- Reset, synchronous on the rst=1 edge:
  - bus_out=0, uart_tx=1, baud=BAUD_DIV_RESET.
  - FIFO empty, rx_valid=0, all sticky flags=0, both FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately; uart_tx is 1 on the next cycle.
- Bus read:
  - Latency 1. If rd=1 and wr=0 at edge N, bus_out holds the selected register at N+1.
  - Otherwise bus_out=0 at N+1. Unmapped address reads 0.
  - DATA reads {24'b0, rx_data}.
  - STATUS reads bits: 0 rx_valid, 1 tx_full, 2 tx_empty, 3 tx_busy (FSM not IDLE or FIFO not empty), 4 rx_ovf, 5 frame_err, 6 tx_ovf; others 0.
  - BAUD reads {16'b0, baud}.
- Bus write: takes effect when wr=1 and rd=1; no response cycle, no stall.
  - DATA write pushes bus_in[7:0] if the FIFO is not full. If full, data is dropped and tx_ovf is set.
  - STATUS write clears bits 4/5/6 where bus_in has a 1.
  - BAUD write loads bus_in[15:0].
- RX pop: a DATA read (rd=1, wr=0, addr=DATA_ADDR) clears rx_valid at the same edge.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Bit counter counts BAUD..0; a state or bit advances on count==0.
  - IDLE with FIFO not empty: pop the head into the shift register and enter START next cycle, uart_tx=0.
  - DATA sends 8 bits LSB first. STOP drives 1 for one bit period.
  - From STOP, go straight to START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - A BAUD write takes effect at the next counter reload; the bit in progress is not truncated.
- TX FIFO:
  - Circular, with wrap-around pointers and an occupancy count of width TX_FIFO_DEPTH_LOG2+1.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, both succeed.
  - Push into a full FIFO while the FSM pops in the same cycle: the push succeeds, no tx_ovf.
- RX FSM, states IDLE -> START -> DATA -> STOP:
  - uart_rx passes through a 2-FF synchronizer; all edge detection uses the synchronized signal.
  - IDLE: on a synchronized 1->0 edge, enter START and wait BAUD/2 (integer shift) clocks.
  - START sample: if 1, it was a glitch; return to IDLE with no flag.
  - DATA: 8 samples, each BAUD+1 clocks apart, shifted in LSB first.
  - STOP sample = 0: set frame_err, discard the byte, rx_valid unchanged.
  - STOP sample = 1: load rx_data and set rx_valid. If rx_valid was already 1 and no pop occurs in that cycle, also set rx_ovf; the new byte overwrites.
  - Pop and byte completion in the same cycle: the new byte wins, rx_valid stays 1, no rx_ovf.
  - Return to IDLE at the STOP sample point; the next start bit may be detected from the following cycle.
- Arithmetic: counters are 16-bit unsigned. BAUD=0 gives 1 clock/bit on TX; RX behaviour with BAUD<3 is unspecified.

Test Plan:
- Reset, then read STATUS at 'h04 -> bus_out=32'h00000004 one cycle later; uart_tx=1; bus_out=0 on the cycle after rd drops.
- BAUD=9, write DATA 'h55 -> uart_tx: start 0, bits 1,0,1,0,1,0,1,0, stop 1; each bit exactly 10 clocks; tx_busy clears 100 clocks after the start bit begins.
- BAUD=9, write 5 bytes 'h01..'h05 back-to-back with no gap -> 'h01 is popped, 'h02..'h05 fill the FIFO; all five serialized contiguously with no idle between stop and start; tx_ovf=0. Repeat with 6 writes -> 6th byte dropped, STATUS bit6=1; writing STATUS 'h40 clears it.
- BAUD=15, drive frame 'hA3 on uart_rx -> rx_valid=1; DATA read returns 'h000000A3 and rx_valid=0. Send a second frame without reading, then a third -> rx_ovf=1, DATA returns the third byte.
- BAUD=15, drive a frame with stop bit 0 -> frame_err=1, rx_valid=0. Drive a 3-clock low glitch -> no flags, RX FSM back in IDLE.
- Assert rst for one cycle mid-TX-data-bit -> uart_tx=1 the next cycle, FIFO empty, baud back to 433, STATUS reads 'h04.

Source files
------------

// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   UART responder on the core's shared program/data bus. A write to DATA
//   pushes a byte into a small TX FIFO drained by a serializer. A read of DATA
//   pops the one-byte RX holding register. STATUS reports FIFO/RX state and
//   holds the sticky error flags (write-1-to-clear). BAUD holds the divisor;
//   one bit period is BAUD+1 clocks.
//
// Ports
//   clk      core clock
//   rst      synchronous active-high reset
//   addr     byte address inside this peripheral's window
//   wr       write strobe (a write needs wr=1 and rd=1)
//   rd       chip select / read enable
//   bus_in   write data
//   bus_out  registered read data, zero when no read was issued
//   uart_tx  serial output, idle high
//   uart_rx  serial input, asynchronous to clk
module uart_bus_responder #(
    parameter int unsigned BUS_ADDR_DATA_LEN  = 13,
    parameter int unsigned DATA_ADDR          = 'h00,
    parameter int unsigned STATUS_ADDR        = 'h04,
    parameter int unsigned BAUD_ADDR          = 'h08,
    parameter int unsigned TX_FIFO_DEPTH_LOG2 = 2,
    parameter logic [15:0] BAUD_DIV_RESET     = 16'd433
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [31:0]                  bus_in,
    output logic [31:0]                  bus_out,
    output logic                         uart_tx,
    input  logic                         uart_rx
);

    localparam int unsigned DEPTH = 1 << TX_FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = TX_FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned PW    = TX_FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ---------------- bus decode ----------------
    logic wr_en, rd_en, sel_data, sel_status, sel_baud;
    assign wr_en      = wr & rd;
    assign rd_en      = rd & ~wr;
    assign sel_data   = (addr == BUS_ADDR_DATA_LEN'(DATA_ADDR));
    assign sel_status = (addr == BUS_ADDR_DATA_LEN'(STATUS_ADDR));
    assign sel_baud   = (addr == BUS_ADDR_DATA_LEN'(BAUD_ADDR));

    logic clr_status;
    assign clr_status = wr_en & sel_status;

    logic unused_bus_hi;
    assign unused_bus_hi = ^bus_in[31:16];

    logic [15:0] baud;
    always_ff @(posedge clk) begin
        if (rst)                   baud <= BAUD_DIV_RESET;
        else if (wr_en & sel_baud) baud <= bus_in[15:0];
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty, tx_pop, push_req, push_ok, tx_ovf;
    uart_state_t   tx_state;
    logic [15:0]   tx_cnt;

    assign fifo_full  = (fifo_cnt == CW'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // The serializer pops from IDLE, or at the end of STOP to chain frames.
    assign tx_pop     = ~fifo_empty &
                        ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == 16'd0)));
    assign push_req   = wr_en & sel_data;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req & (~fifo_full | tx_pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (clr_status & bus_in[6]) tx_ovf <= 1'b0;
            if (push_req & ~push_ok)    tx_ovf <= 1'b1;
        end
    end

    // ---------------- TX serializer ----------------
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_shift <= fifo_mem[rd_ptr];
                    tx_cnt   <= baud;
                    uart_tx  <= 1'b0;
                    tx_state <= S_START;
                end
                S_START: if (tx_cnt == 16'd0) begin
                    uart_tx  <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= 3'd0;
                    tx_cnt   <= baud;
                    tx_state <= S_DATA;
                end else tx_cnt <= tx_cnt - 16'd1;
                S_DATA: if (tx_cnt == 16'd0) begin
                    tx_cnt <= baud;
                    if (tx_bit == 3'd7) begin
                        uart_tx  <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                S_STOP: if (tx_cnt == 16'd0) begin
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= baud;
                        uart_tx  <= 1'b0;
                        tx_state <= S_START;
                    end else tx_state <= S_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX deserializer ----------------
    uart_state_t rx_state;
    logic [1:0]  rx_sync;
    logic        rx_prev, rx_line, rx_pop, rx_valid, rx_ovf, frame_err;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_data;

    assign rx_line = rx_sync[1];
    assign rx_pop  = rd_en & sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync   <= 2'b11;
            rx_prev   <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= 16'd0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_line;
            // Clears first; a byte completing this cycle overrides below.
            if (rx_pop)                 rx_valid  <= 1'b0;
            if (clr_status & bus_in[4]) rx_ovf    <= 1'b0;
            if (clr_status & bus_in[5]) frame_err <= 1'b0;
            case (rx_state)
                S_IDLE: if (rx_prev & ~rx_line) begin
                    rx_cnt   <= {1'b0, baud[15:1]};  // land on mid start bit
                    rx_state <= S_START;
                end
                S_START: if (rx_cnt == 16'd0) begin
                    if (rx_line) rx_state <= S_IDLE;  // glitch
                    else begin
                        rx_cnt   <= baud;
                        rx_bit   <= 3'd0;
                        rx_state <= S_DATA;
                    end
                end else rx_cnt <= rx_cnt - 16'd1;
                S_DATA: if (rx_cnt == 16'd0) begin
                    rx_shift <= {rx_line, rx_shift[7:1]};
                    rx_cnt   <= baud;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                    else                rx_bit   <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_STOP: if (rx_cnt == 16'd0) begin
                    rx_state <= S_IDLE;
                    if (rx_line) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        if (rx_valid & ~rx_pop) rx_ovf <= 1'b1;
                    end else frame_err <= 1'b1;
                end else rx_cnt <= rx_cnt - 16'd1;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- read mux ----------------
    logic        tx_busy;
    logic [31:0] rdata;
    assign tx_busy = (tx_state != S_IDLE) | ~fifo_empty;

    always_comb begin
        rdata = 32'd0;
        if (sel_data)        rdata = {24'd0, rx_data};
        else if (sel_status) rdata = {25'd0, tx_ovf, frame_err, rx_ovf, tx_busy,
                                      fifo_empty, fifo_full, rx_valid};
        else if (sel_baud)   rdata = {16'd0, baud};
    end

    always_ff @(posedge clk) begin
        if (rst) bus_out <= 32'd0;
        else     bus_out <= rd_en ? rdata : 32'd0;
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder: bus register access, TX framing and
// FIFO chaining/overflow, RX reception/overrun/framing/glitch, mid-frame reset.
module tb_uart_bus_responder;

    localparam logic [12:0] A_DATA   = 13'h00;
    localparam logic [12:0] A_STATUS = 13'h04;
    localparam logic [12:0] A_BAUD   = 13'h08;

    logic        clk = 1'b0;
    logic        rst, wr, rd, uart_tx, uart_rx;
    logic [12:0] addr;
    logic [31:0] bus_in, bus_out;

    int n_cmp = 0;
    int n_err = 0;

    uart_bus_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
        .bus_in(bus_in), .bus_out(bus_out), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [31:0] d);
        addr = a; bus_in = d; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [31:0] d);
        addr = a; wr = 1'b0; rd = 1'b1;
        tick();
        d = bus_out;
        rd = 1'b0;
    endtask

    // Drive one 16-clock-per-bit frame (BAUD=15) on uart_rx, then idle high.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) tick();
        end
        uart_rx = stop_bit;
        repeat (16) tick();
        uart_rx = 1'b1;
        repeat (4) tick();
    endtask

    // Line level expected in bit slot j (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (bus_out !== 32'd0) begin n_err++; $display("FAIL reset_bus_out: got %h want 0", bus_out); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL reset_status: got %h want 00000004", d); end
        tick();
        n_cmp++; if (bus_out !== 32'd0) begin n_err++; $display("FAIL bus_out_after_rd: got %h want 0", bus_out); end
        bus_read(A_BAUD, d);
        n_cmp++; if (d !== 32'd433) begin n_err++; $display("FAIL reset_baud: got %h want 1b1", d); end
        bus_read(13'h0C, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", d); end
        bus_write(A_BAUD, 32'hFFFF_0009);
        bus_read(A_BAUD, d);
        n_cmp++; if (d !== 32'd9) begin n_err++; $display("FAIL baud_rw: got %h want 9", d); end
    endtask

    task automatic test_tx_single;
        logic [31:0] d;
        int n;
        bus_write(A_DATA, 32'h55);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin tick(); n++; end
        n_cmp++; if (n >= 20) begin n_err++; $display("FAIL tx_start_timeout: got %0d cycles want <20", n); end
        for (int k = 0; k < 100; k++) begin
            n_cmp++;
            if (uart_tx !== frame_bit(8'h55, k / 10)) begin
                n_err++; $display("FAIL tx55_bit k=%0d: got %b want %b", k, uart_tx, frame_bit(8'h55, k / 10));
            end
            if (k < 99) tick();
        end
        // Still in the stop bit this cycle, idle on the next.
        addr = A_STATUS; rd = 1'b1;
        tick();
        n_cmp++; if (bus_out !== 32'h0C) begin n_err++; $display("FAIL tx_busy_last: got %h want 0000000c", bus_out); end
        tick();
        n_cmp++; if (bus_out !== 32'h04) begin n_err++; $display("FAIL tx_busy_clear: got %h want 00000004", bus_out); end
        rd = 1'b0;
        tick();
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL tx_idle_status: got %h want 00000004", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int n;
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, 32'(i));
        // First start bit began the cycle after the first push; we are 3 in.
        for (int k = 3; k < 500; k++) begin
            n_cmp++;
            if (uart_tx !== frame_bit(8'(k / 100 + 1), (k % 100) / 10)) begin
                n_err++; $display("FAIL b2b_bit k=%0d: got %b want %b", k, uart_tx, frame_bit(8'(k / 100 + 1), (k % 100) / 10));
            end
            tick();
        end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL b2b_status: got %h want 00000004", d); end

        for (int i = 1; i <= 6; i++) bus_write(A_DATA, 32'(i));
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h4A) begin n_err++; $display("FAIL tx_ovf_set: got %h want 0000004a", d); end
        bus_write(A_STATUS, 32'h40);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h0A) begin n_err++; $display("FAIL tx_ovf_clear: got %h want 0000000a", d); end
        n = 0;
        do begin
            repeat (10) tick();
            bus_read(A_STATUS, d);
            n++;
        end while (d[3] !== 1'b0 && n < 80);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL tx_drain: got %h want 00000004 after %0d polls", d, n); end
    endtask

    task automatic test_rx;
        logic [31:0] d;
        bus_write(A_BAUD, 32'd15);
        send_rx(8'hA3, 1'b1);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h05) begin n_err++; $display("FAIL rx_valid: got %h want 00000005", d); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'hA3) begin n_err++; $display("FAIL rx_data_a3: got %h want 000000a3", d); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL rx_pop: got %h want 00000004", d); end
        send_rx(8'h11, 1'b1);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h05) begin n_err++; $display("FAIL rx_second: got %h want 00000005", d); end
        send_rx(8'h22, 1'b1);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h15) begin n_err++; $display("FAIL rx_ovf: got %h want 00000015", d); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'h22) begin n_err++; $display("FAIL rx_overwrite: got %h want 00000022", d); end
        bus_write(A_STATUS, 32'h10);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL rx_ovf_clear: got %h want 00000004", d); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] d;
        send_rx(8'h5A, 1'b0);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h24) begin n_err++; $display("FAIL frame_err: got %h want 00000024", d); end
        bus_write(A_STATUS, 32'h20);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL frame_err_clear: got %h want 00000004", d); end
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL glitch_flags: got %h want 00000004", d); end
        send_rx(8'h3C, 1'b1);
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'h3C) begin n_err++; $display("FAIL after_glitch: got %h want 0000003c", d); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] d;
        int n;
        bus_write(A_BAUD, 32'd9);
        bus_write(A_DATA, 32'h00);
        bus_write(A_DATA, 32'h7E);
        bus_write(A_DATA, 32'h81);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin tick(); n++; end
        n_cmp++; if (n >= 20) begin n_err++; $display("FAIL rst_tx_start_timeout: got %0d cycles want <20", n); end
        repeat (14) tick();
        n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_data_bit: got %b want 0", uart_tx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
        bus_read(A_BAUD, d);
        n_cmp++; if (d !== 32'd433) begin n_err++; $display("FAIL rst_baud: got %h want 000001b1", d); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL rst_status: got %h want 00000004", d); end
        n = 0;
        repeat (20) begin tick(); if (uart_tx !== 1'b1) n++; end
        n_cmp++; if (n != 0) begin n_err++; $display("FAIL rst_tx_idle: got %0d low cycles want 0", n); end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; bus_in = '0; uart_rx = 1'b1;
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
